buyruk_bellegi: RTL and testbench

Instruction memory with a built-in UART program loader, sitting directly upstream of the single-cycle RV32I core. It receives a program over a serial line and writes it into an on-chip word array. While loading, it holds the core in reset. After loading, it returns one instruction word per cycle, addressed by the core's next-PC output `ps`.

---
 rtl/buyruk_bellegi.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_buyruk_bellegi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/buyruk_bellegi.sv
// -----------------------------------------------------------------------------
// buyruk_bellegi
//   Instruction memory for the single-cycle RV32I core. It has a built-in UART
//   program loader.
//
//   Load protocol:
//     - The host sends a 32-bit word count N (little-endian).
//     - It then sends N little-endian words. Word k is written to mem[k].
//   While loading, the core is held in reset. After the last word:
//     - one BASLAT cycle presents mem[0];
//     - the block then serves one instruction per cycle, addressed by the
//       core's next-PC.
//
//   Parameters
//     DERINLIK     memory depth in 32-bit words (power of two)
//     CLK_PER_BIT  clock cycles per UART bit
//
//   Ports
//     clk            clock
//     rst            synchronous, active-high reset
//     uart_rx        8N1 serial input, idle high, asynchronous to clk
//     ps             next PC from the core (fetch address)
//     buyruk         registered instruction word to the core
//     islemci_rst    registered core reset, high except in CALISTIR
//     yukleme_bitti  high while in CALISTIR
//     hata           sticky error flag, cleared only by rst
//
//   Build option
//     BUYRUK_ILK_YUKLEME_EN
//       - Reset goes straight to BASLAT.
//       - The UART receiver is left out.
// -----------------------------------------------------------------------------
module buyruk_bellegi #(
   parameter int DERINLIK    = 256,
   parameter int CLK_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   input  logic [31:0] ps,
   output logic [31:0] buyruk,
   output logic        islemci_rst,
   output logic        yukleme_bitti,
   output logic        hata
);

   localparam int          AW    = $clog2(DERINLIK);
   localparam int          CW    = $clog2(CLK_PER_BIT);
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] DER32 = 32'(DERINLIK);

   typedef enum logic [2:0] {
      SAYI_AL,
      VERI_AL,
      BASLAT,
      CALISTIR,
      HATA
   } durum_t;

   logic [31:0]   r_mem [DERINLIK];

   durum_t        r_durum;
   logic [31:0]   r_buyruk;
   logic          r_islemci_rst;
   logic          r_yukleme_bitti;
   logic          r_hata;
   logic [23:0]   r_topla;      // first three bytes of the word being assembled
   logic [1:0]    r_bayt_say;
   logic [AW-1:0] r_idx;
   logic [AW:0]   r_n;          // word count; N <= DERINLIK fits in AW+1 bits

   logic          w_bayt_gecerli;
   logic          w_cerceve_hata;
   logic [7:0]    w_bayt;
   logic [31:0]   w_kelime;
   logic          w_yaz;
   logic          w_son_kelime;
   logic          w_ps_disi;
   logic          w_ps_hizasiz;
   logic [AW-1:0] w_ps_idx;

   // --------------------------------------------------------------------------
   // UART receiver.
   // Emits a one-cycle byte-valid or framing-error strobe on the cycle the stop
   // bit is sampled.
   // --------------------------------------------------------------------------
`ifdef BUYRUK_ILK_YUKLEME_EN
   assign w_bayt_gecerli = 1'b0;
   assign w_cerceve_hata = 1'b0;
   assign w_bayt         = 8'h00;
`else
   typedef enum logic [1:0] {
      RX_BOS,
      RX_BASLA,
      RX_VERI,
      RX_DUR
   } rx_durum_t;

   localparam logic [CW-1:0] BIT_SON   = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] YARIM_SON = CW'(CLK_PER_BIT / 2 - 1);

   rx_durum_t     r_rx_durum;
   logic          r_rx_s1;
   logic          r_rx_s2;
   logic          r_rx_onceki;
   logic [CW-1:0] r_rx_say;
   logic [2:0]    r_rx_bit;
   logic [7:0]    r_rx_kaydir;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1     <= 1'b1;
         r_rx_s2     <= 1'b1;
         r_rx_onceki <= 1'b1;
         r_rx_durum  <= RX_BOS;
         r_rx_say    <= '0;
         r_rx_bit    <= '0;
         r_rx_kaydir <= '0;
      end else begin
         r_rx_s1     <= uart_rx;
         r_rx_s2     <= r_rx_s1;
         r_rx_onceki <= r_rx_s2;
         case (r_rx_durum)
            RX_BOS: begin
               // Only a genuine high-to-low transition starts a byte.
               // A line stuck low does not retrigger.
               if (r_rx_onceki && !r_rx_s2) begin
                  r_rx_durum <= RX_BASLA;
                  r_rx_say   <= '0;
               end
            end
            RX_BASLA: begin
               if (r_rx_say == YARIM_SON) begin
                  r_rx_say   <= '0;
                  r_rx_bit   <= '0;
                  // A glitch that is high again at mid-start is dropped.
                  r_rx_durum <= r_rx_s2 ? RX_BOS : RX_VERI;
               end else begin
                  r_rx_say <= r_rx_say + CW'(1);
               end
            end
            RX_VERI: begin
               if (r_rx_say == BIT_SON) begin
                  r_rx_say    <= '0;
                  r_rx_kaydir <= {r_rx_s2, r_rx_kaydir[7:1]};   // LSB first
                  r_rx_bit    <= r_rx_bit + 3'd1;
                  if (r_rx_bit == 3'd7)
                     r_rx_durum <= RX_DUR;
               end else begin
                  r_rx_say <= r_rx_say + CW'(1);
               end
            end
            RX_DUR: begin
               if (r_rx_say == BIT_SON) begin
                  r_rx_say   <= '0;
                  r_rx_durum <= RX_BOS;
               end else begin
                  r_rx_say <= r_rx_say + CW'(1);
               end
            end
            default: r_rx_durum <= RX_BOS;
         endcase
      end
   end

   assign w_bayt_gecerli = (r_rx_durum == RX_DUR) && (r_rx_say == BIT_SON) &&  r_rx_s2;
   assign w_cerceve_hata = (r_rx_durum == RX_DUR) && (r_rx_say == BIT_SON) && !r_rx_s2;
   assign w_bayt         = r_rx_kaydir;
`endif

   // --------------------------------------------------------------------------
   // Word assembly and memory write.
   // The 4th byte is combined with the three held bytes and written on the
   // same edge that completes it.
   // --------------------------------------------------------------------------
   assign w_kelime     = {w_bayt, r_topla};
   assign w_yaz        = !rst && (r_durum == VERI_AL) && w_bayt_gecerli && (r_bayt_say == 2'd3);
   assign w_son_kelime = (({1'b0, r_idx} + (AW+1)'(1)) == r_n);

   always_ff @(posedge clk) begin
      if (w_yaz)
         r_mem[r_idx] <= w_kelime;
   end

   // --------------------------------------------------------------------------
   // Fetch address decode
   // --------------------------------------------------------------------------
   assign w_ps_idx     = ps[AW+1:2];
   assign w_ps_disi    = ({2'b00, ps[31:2]} >= DER32);
   assign w_ps_hizasiz = (ps[1:0] != 2'b00);

   // --------------------------------------------------------------------------
   // Loader / fetch state machine with registered outputs
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef BUYRUK_ILK_YUKLEME_EN
         r_durum <= BASLAT;
`else
         r_durum <= SAYI_AL;
`endif
         r_buyruk        <= NOP;
         r_islemci_rst   <= 1'b1;
         r_yukleme_bitti <= 1'b0;
         r_hata          <= 1'b0;
         r_topla         <= '0;
         r_bayt_say      <= '0;
         r_idx           <= '0;
         r_n             <= '0;
      end else begin
         case (r_durum)
            SAYI_AL: begin
               r_buyruk      <= NOP;
               r_islemci_rst <= 1'b1;
               if (w_cerceve_hata) begin
                  r_durum <= HATA;
                  r_hata  <= 1'b1;
               end else if (w_bayt_gecerli) begin
                  r_topla    <= w_kelime[31:8];
                  r_bayt_say <= r_bayt_say + 2'd1;
                  if (r_bayt_say == 2'd3) begin
                     if ((w_kelime == 32'd0) || (w_kelime > DER32)) begin
                        r_durum <= HATA;
                        r_hata  <= 1'b1;
                     end else begin
                        r_n     <= w_kelime[AW:0];
                        r_idx   <= '0;
                        r_durum <= VERI_AL;
                     end
                  end
               end
            end
            VERI_AL: begin
               r_buyruk      <= NOP;
               r_islemci_rst <= 1'b1;
               if (w_cerceve_hata) begin
                  r_durum <= HATA;
                  r_hata  <= 1'b1;
               end else if (w_bayt_gecerli) begin
                  r_topla    <= w_kelime[31:8];
                  r_bayt_say <= r_bayt_say + 2'd1;
                  if (r_bayt_say == 2'd3) begin
                     if (w_son_kelime)
                        r_durum <= BASLAT;
                     else
                        r_idx <= r_idx + AW'(1);
                  end
               end
            end
            BASLAT: begin
               // Core is still in reset this cycle, so its PC is 0.
               // mem[0] lines up with the core's first instruction.
               r_buyruk        <= r_mem[0];
               r_islemci_rst   <= 1'b0;
               r_yukleme_bitti <= 1'b1;
               r_durum         <= CALISTIR;
            end
            CALISTIR: begin
               // A bad fetch feeds a NOP and flags the error.
               // The core keeps running.
               if (w_ps_disi || w_ps_hizasiz) begin
                  r_buyruk <= NOP;
                  r_hata   <= 1'b1;
               end else begin
                  r_buyruk <= r_mem[w_ps_idx];
               end
            end
            HATA: begin
               r_buyruk        <= NOP;
               r_islemci_rst   <= 1'b1;
               r_yukleme_bitti <= 1'b0;
               r_hata          <= 1'b1;
            end
            default: begin
               r_durum <= HATA;
               r_hata  <= 1'b1;
            end
         endcase
      end
   end

   assign buyruk        = r_buyruk;
   assign islemci_rst   = r_islemci_rst;
   assign yukleme_bitti = r_yukleme_bitti;
   assign hata          = r_hata;

endmodule

// File: tb/tb_buyruk_bellegi.sv
// -----------------------------------------------------------------------------
// tb_buyruk_bellegi
//   Directed bench for buyruk_bellegi.
//   A short bit period keeps the serial loads fast.
// -----------------------------------------------------------------------------
module tb_buyruk_bellegi;

   localparam int CPB = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_rx;
   logic [31:0] ps;
   logic [31:0] buyruk;
   logic        islemci_rst;
   logic        yukleme_bitti;
   logic        hata;

   int checks = 0;
   int errors = 0;

   buyruk_bellegi #(.DERINLIK(256), .CLK_PER_BIT(CPB)) dut (
      .clk           (clk),
      .rst           (rst),
      .uart_rx       (uart_rx),
      .ps            (ps),
      .buyruk        (buyruk),
      .islemci_rst   (islemci_rst),
      .yukleme_bitti (yukleme_bitti),
      .hata          (hata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives start and data bits, then leaves the stop bit on the line.
   // Returns just after the edge on which the stop bit was first driven.
   task automatic send_head(input logic [7:0] b, input logic stop_bit);
      @(posedge clk); #1 uart_rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clk);
         #1 uart_rx = b[i];
      end
      repeat (CPB) @(posedge clk);
      #1 uart_rx = stop_bit;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      send_head(b, stop_bit);
      repeat (CPB) @(posedge clk);
      #1 uart_rx = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; uart_rx = 1'b1; ps = 32'd0;

      // 1. reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_islemci_rst", islemci_rst, 1);
      chk("rst_buyruk", buyruk, NOP);
      chk("rst_yukleme_bitti", yukleme_bitti, 0);
      chk("rst_hata", hata, 0);
      rst = 1'b0;

      // 2. normal load, N=2, with exact completion timing on the last byte
      send_word(32'd2);
      send_word(32'h0050_0093);
      send_byte(8'h13, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hA0, 1'b1);
      send_head(8'h00, 1'b1);
      repeat (11) @(posedge clk);   // stop bit sampled on this edge (cycle T)
      #1;
      chk("T1_islemci_rst", islemci_rst, 1);
      chk("T1_yukleme_bitti", yukleme_bitti, 0);
      @(posedge clk); #1;
      chk("T2_islemci_rst", islemci_rst, 0);
      chk("T2_yukleme_bitti", yukleme_bitti, 1);
      chk("T2_buyruk", buyruk, 32'h0050_0093);
      chk("T2_hata", hata, 0);
      repeat (4) @(posedge clk);
      #1 uart_rx = 1'b1;

      ps = 32'd4; @(posedge clk); #1;
      chk("fetch_ps4", buyruk, 32'h00A0_0113);

      // 5a. out-of-range fetch
      ps = 32'h400; @(posedge clk); #1;
      chk("oor_buyruk", buyruk, NOP);
      chk("oor_hata", hata, 1);
      chk("oor_islemci_rst", islemci_rst, 0);
      ps = 32'd0; @(posedge clk); #1;
      chk("oor_resume", buyruk, 32'h0050_0093);

      // 3. bad counts
      reset_pulse();
      send_word(32'd0);
      chk("n0_hata", hata, 1);
      chk("n0_buyruk", buyruk, NOP);
      repeat (1000) @(posedge clk);
      #1;
      chk("n0_islemci_rst_1000", islemci_rst, 1);
      chk("n0_yukleme_bitti", yukleme_bitti, 0);

      reset_pulse();
      chk("hata_cleared", hata, 0);
      send_word(32'd257);
      chk("n257_hata", hata, 1);
      chk("n257_islemci_rst", islemci_rst, 1);

      reset_pulse();
      send_word(32'd256);           // exactly the depth is accepted
      chk("n256_hata", hata, 0);
      chk("n256_islemci_rst", islemci_rst, 1);

      // 4. framing error on 2nd count byte; later bytes are ignored
      reset_pulse();
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b0);
      chk("frame_hata", hata, 1);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      send_word(32'h1122_3344);
      chk("frame_hata_kalir", hata, 1);
      chk("frame_islemci_rst", islemci_rst, 1);
      chk("frame_yukleme_bitti", yukleme_bitti, 0);
      chk("frame_buyruk", buyruk, NOP);

      // 6. reset mid-load, then a fresh one-word load
      reset_pulse();
      send_word(32'd2);
      send_byte(8'h93, 1'b1);
      reset_pulse();
      send_word(32'd1);
      send_word(32'hDEAD_BEEF);
      chk("midrst_buyruk", buyruk, 32'hDEAD_BEEF);
      chk("midrst_islemci_rst", islemci_rst, 0);
      chk("midrst_hata", hata, 0);

      // words past N keep their old contents
      ps = 32'd4; @(posedge clk); #1;
      chk("retain_mem1", buyruk, 32'h00A0_0113);

      // last in-range word is not an error
      ps = 32'h3FC; @(posedge clk); #1;
      chk("edge_3fc_hata", hata, 0);

      // 5b. misaligned fetch
      ps = 32'h2; @(posedge clk); #1;
      chk("mis_buyruk", buyruk, NOP);
      chk("mis_hata", hata, 1);
      chk("mis_islemci_rst", islemci_rst, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
